// File: rtl/seq_u_cla_pkg.sv
// Shared types and constants for the digit-serial CLA nibble adder.
package seq_u_cla_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIB_W = 4;

  // Width of the nibble index counter; never narrower than one bit.
  function automatic int idx_w(input int width);
    int n;
    n = width / NIB_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_u_cla_nibble_adder_cla4.sv
// Combinational 4-bit carry-lookahead slice with carry-in.
module cla4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] x;
  logic [3:0] c;

  assign g = a & b;
  assign p = a | b;
  assign x = a ^ b;

  // Fully expanded lookahead: every carry depends only on g, p and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = x ^ c;

endmodule

// File: rtl/seq_u_cla_nibble_adder.sv
// Digit-serial unsigned adder: one 4-bit CLA slice per cycle, carry held in a flop.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one nibble per cycle, low nibble first
// DONE  | full sum on out, out_valid=1 until out_ready
module seq_u_cla_nibble_adder
  import seq_u_cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH:0]   out_q;
  logic [3:0]       s_nib;
  logic             c_nib;

  // Operands shift right each RUN cycle, so the slice always sees bits [3:0].
  cla4_cin u_slice (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (s_nib),
    .cout (c_nib)
  );

  always_comb begin
    res_nxt = res_q;
    for (int k = 0; k < NIB; k++) begin
      if (idx_q == IW'(k)) res_nxt[k*NIB_W +: NIB_W] = s_nib;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> NIB_W;
          b_q     <= b_q >> NIB_W;
          res_q   <= res_nxt;
          carry_q <= c_nib;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            out_q <= {c_nib, res_nxt};
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_seq_u_cla_nibble_adder.sv
// Directed vector table plus randomized stall checks for the serial CLA adder.
module tb_seq_u_cla_nibble_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] a = '0, b = '0;
  logic [16:0] out;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic        in_ready4, out_valid4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [4:0]  out4;

  logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
  logic        in_ready32, out_valid32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [32:0] out32;

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd_on = 1'b0;

  logic [32:0] q16[$];
  logic [32:0] q4[$];
  logic [32:0] q32[$];

  always #5 clk = ~clk;

  seq_u_cla_nibble_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  seq_u_cla_nibble_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .out(out4)
  );

  seq_u_cla_nibble_adder #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32), .out(out32)
  );

  function automatic void chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endfunction

  // Scoreboards: inputs are stable at negedge, so a handshake seen here lands on the next posedge.
  always @(negedge clk) begin
    if (rnd_on) begin
      if (in_valid && in_ready) q16.push_back(33'(a) + 33'(b));
      if (out_valid && out_ready) begin
        if (q16.size() == 0) chk("rnd16_extra", 33'(out), 33'h1_ffff_ffff);
        else chk("rnd16", 33'(out), q16.pop_front());
      end
      if (in_valid4 && in_ready4) q4.push_back(33'(a4) + 33'(b4));
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) chk("rnd4_extra", 33'(out4), 33'h1_ffff_ffff);
        else chk("rnd4", 33'(out4), q4.pop_front());
      end
      if (in_valid32 && in_ready32) q32.push_back(33'(a32) + 33'(b32));
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) chk("rnd32_extra", out32, 33'h1_ffff_ffff);
        else chk("rnd32", out32, q32.pop_front());
      end
    end
  end

  // Called at posedge+1 with u16 in IDLE; returns at posedge+1 with u16 back in IDLE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                        input logic [16:0] exp, input int hold, input string nm);
    int lat;
    int run_changes;
    int hold_bad;
    logic [16:0] prev;
    prev = out;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    run_changes = 0;
    while (!out_valid && lat < 20) begin
      if (out !== prev) run_changes++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 33'(lat), 33'd4);
    chk({nm, "_run_out_stable"}, 33'(run_changes), 33'd0);
    chk({nm, "_sum"}, 33'(out), 33'(exp));
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
      if (out !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) hold_bad++;
    end
    if (hold > 0) chk({nm, "_hold"}, 33'(hold_bad), 33'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_idle_ready"}, 33'(in_ready), 33'd1);
    chk({nm, "_idle_valid"}, 33'(out_valid), 33'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int quiet_bad;

    vecs[0] = '{16'hFFFF, 16'h0001, 17'h10000};
    vecs[1] = '{16'h1234, 16'h4321, 17'h05555};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[3] = '{16'h0000, 16'h0000, 17'h00000};
    vecs[4] = '{16'h8000, 16'h8000, 17'h10000};
    vecs[5] = '{16'hABCD, 16'h1111, 17'h0BCDE};
    vecs[6] = '{16'h0F0F, 16'hF0F1, 17'h10000};
    vecs[7] = '{16'h7FFF, 16'h0001, 17'h08000};
    vecs[8] = '{16'h00FF, 16'h0001, 17'h00100};

    #2 rst = 1'b1;
    #2;
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out", 33'(out), 33'd0);
    #19 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));

    // Backpressure in DONE while in_valid and operands toggle.
    run_op(16'h1234, 16'h1111, 17'h02345, 6, "bp");
    quiet_bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || out !== 17'h02345) quiet_bad++;
    end
    chk("bp_no_capture", 33'(quiet_bad), 33'd0);

    // Asynchronous reset mid-cycle while idle with a nonzero held result.
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ready", 33'(in_ready), 33'd1);
    chk("async_rst_valid", 33'(out_valid), 33'd0);
    chk("async_rst_out", 33'(out), 33'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Reset during the second RUN cycle discards the operation.
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_ready", 33'(in_ready), 33'd1);
    chk("midrun_rst_valid", 33'(out_valid), 33'd0);
    #2 rst = 1'b0;
    quiet_bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet_bad++;
    end
    chk("midrun_never_valid", 33'(quiet_bad), 33'd0);
    run_op(16'h00FF, 16'h0001, 17'h00100, 0, "after_rst");

    // Random stimulus on all three widths with stalls on both sides.
    rnd_on = 1'b1;
    repeat (6000) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      a           = 16'($urandom);
      b           = 16'($urandom);
      out_ready   = ($urandom_range(0, 2) != 0);
      in_valid4   = ($urandom_range(0, 3) != 0);
      a4          = 4'($urandom);
      b4          = 4'($urandom);
      out_ready4  = ($urandom_range(0, 2) != 0);
      in_valid32  = ($urandom_range(0, 3) != 0);
      a32         = $urandom;
      b32         = $urandom;
      out_ready32 = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    in_valid32 = 1'b0;
    out_ready = 1'b1;
    out_ready4 = 1'b1;
    out_ready32 = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
    end
    rnd_on = 1'b0;
    chk("rnd16_drained", 33'(q16.size()), 33'd0);
    chk("rnd4_drained", 33'(q4.size()), 33'd0);
    chk("rnd32_drained", 33'(q32.size()), 33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
